mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single core memory port between instruction fetch (IFU) and load/store (LSU).
//  One transaction is outstanding at a time. Each accepted request is latched, issued to memory,
//  and its response is routed back to the requester that owns it.
//  Sits between IFU/LSU and the memory interface; the LSU drives mem_wen/mem_ren/mem_mask as decoded by control.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   64  data width (RV64)
//  MASK_W   8   byte-write mask width (DATA_W/8)
//  RR_EN    0   0: LSU has fixed priority; 1: round-robin when both requesters are valid
//  TIMEOUT  255 max cycles waiting in ISSUE+WAIT before abort; 0 disables the watchdog
// PORTS
//  clk            in  1       clock, rising edge
//  rst_n          in  1       synchronous, active-low reset
//  ifu_req_valid  in  1       IFU read request
//  ifu_req_ready  out 1       IFU request accepted this cycle
//  ifu_addr       in  ADDR_W  fetch address
//  ifu_resp_valid out 1       1-cycle pulse; ifu_rdata valid
//  ifu_rdata      out DATA_W  fetched data
//  lsu_req_valid  in  1       LSU request
//  lsu_req_ready  out 1       LSU request accepted this cycle
//  lsu_addr       in  ADDR_W  load/store address
//  lsu_wen        in  1       1 = store, 0 = load
//  lsu_wdata      in  DATA_W  store data
//  lsu_wmask      in  MASK_W  store byte mask
//  lsu_resp_valid out 1       1-cycle pulse; load data valid, or store acknowledged
//  lsu_rdata      out DATA_W  load data (0 for stores)
//  mem_req_valid  out 1       request to memory
//  mem_req_ready  in  1       memory accepts the request
//  mem_addr/mem_wdata/mem_wmask/mem_wen/mem_ren  out  ADDR_W/DATA_W/MASK_W/1/1  latched request
//  mem_resp_valid in  1       memory response
//  mem_rdata      in  DATA_W  memory read data
//  mem_err        out 1       sticky; set on watchdog timeout, cleared only by reset
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE, owner=IFU, last_owner=IFU, counter=0.
//   All outputs are 0, including the latched mem_* buses and *_rdata. Any in-flight transaction is dropped.
//  FSM IDLE -> ISSUE -> WAIT -> IDLE.
//  IDLE: if any req_valid is high, pick a winner and drive its req_ready=1 combinationally in that cycle.
//   Latch addr/wdata/wmask/wen into regs and owner into a reg. Set mem_ren=~wen; IFU requests always have wen=0.
//   Next state is ISSUE. The loser's req_ready stays 0.
//  Arbitration: RR_EN=0 -> LSU wins when both are valid.
//   RR_EN=1 -> the winner is the requester that is not last_owner. last_owner updates on every grant.
//  ISSUE: mem_req_valid=1 with stable latched buses until mem_req_ready=1, then go to WAIT.
//   mem_req_valid drops in the cycle after the handshake.
//  WAIT: on mem_resp_valid, register mem_rdata. In the next cycle, pulse <owner>_resp_valid for exactly 1 cycle.
//   Store: rdata=0. State returns to IDLE in that same cycle. A new grant is allowed in that same cycle.
//  Latency: best case accept@N, mem_req_valid@N+1; with ready@N+1 and resp@N+2, resp_valid@N+3.
//  Watchdog: counter clears on grant and increments every cycle in ISSUE/WAIT.
//   If TIMEOUT!=0 and counter==TIMEOUT: set mem_err, pulse owner resp_valid with rdata=0, drop mem_req_valid, go to IDLE.
//  mem_resp_valid in IDLE or ISSUE is a stray response. It is ignored and never routed.
//  Both *_resp_valid are never high in the same cycle. Both *_req_ready are never high in the same cycle.
//  Requester inputs are sampled only in the accept cycle. Later changes have no effect.
// STRUCTURE
//  defines.v: state encodings (ARB_IDLE/ARB_ISSUE/ARB_WAIT) and owner codes (ARB_OWN_IFU/ARB_OWN_LSU).
//  Sub-module arb_rr_pick: 2-way combinational picker (req[1:0], last, rr_en -> grant[1:0]).
//   The FSM, latches and watchdog stay in mem_arbiter.
// TESTING
//  IFU read only, mem ready immediately, resp 1 cycle later, rdata=64'hDEAD_BEEF
//   -> ifu_resp_valid one pulse at cycle accept+3 with that data; lsu_resp_valid stays 0.
//  Both valid in the same cycle, RR_EN=0 -> LSU granted first.
//   IFU is granted in the IDLE cycle of the LSU response; IFU gets the next response.
//  RR_EN=1, both held valid for 4 transactions -> grants alternate LSU,IFU,LSU,IFU (last_owner=IFU after reset).
//  LSU sd: addr=0x8000_0010, wdata=0x1122334455667788, wmask=8'hFF
//   -> mem_wen=1, mem_ren=0, buses stable through 3 cycles of mem_req_ready=0; lsu_resp_valid pulses with rdata=0.
//  TIMEOUT=4, memory never responds -> mem_err=1; owner resp_valid pulses with rdata=0 and the FSM returns to IDLE.
//   A stray mem_resp_valid afterwards produces no resp pulse.
//  rst_n=0 during WAIT -> next cycle all outputs are 0 and state is IDLE.
//   A late mem_resp_valid is ignored and mem_err is cleared.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory-port arbiter: FSM states, owner codes
// and the grant-vector bit positions used by the picker.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_OWN_IFU = 1'b0,
    ARB_OWN_LSU = 1'b1
  } arb_owner_t;

  // Bit positions inside the 2-bit request/grant vectors.
  localparam int GNT_IFU = 0;
  localparam int GNT_LSU = 1;

  // Map a one-hot grant vector to the owner code that gets latched.
  function automatic arb_owner_t grant_owner(input logic [1:0] grant);
    return grant[GNT_LSU] ? ARB_OWN_LSU : ARB_OWN_IFU;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way combinational picker. With a single requester it grants that one;
// with both it grants the LSU unless round-robin is on and the LSU went last.
module arb_rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  arb_owner_t last,
  input  logic       rr_en,
  output logic [1:0] grant
);

  // One-hot grant from the request vector and previous owner.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      if (rr_en && (last == ARB_OWN_LSU)) begin
        grant[GNT_IFU] = 1'b1;
      end else begin
        grant[GNT_LSU] = 1'b1;
      end
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between instruction fetch and load/store.
// One transaction in flight; the accepted request is latched, issued, and the
// response is returned as a registered one-cycle pulse to its owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int MASK_W  = 8,
  parameter int RR_EN   = 0,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  output logic              mem_wen,
  output logic              mem_ren,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  arb_owner_t        last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic              wen_q, wen_d;
  logic              ren_q, ren_d;
  logic              err_q, err_d;
  logic              ifu_resp_q, ifu_resp_d;
  logic              lsu_resp_q, lsu_resp_d;
  logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d;
  logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;

  logic [1:0]        grant;
  logic              timeout_hit;
  logic              finish;
  logic [DATA_W-1:0] resp_data;

  arb_rr_pick u_pick (
    .req   ({lsu_req_valid, ifu_req_valid}),
    .last  (last_q),
    .rr_en (RR_EN != 0),
    .grant (grant)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

  // Next-state, request latching, watchdog and response routing.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    wen_d         = wen_q;
    ren_d         = ren_q;
    err_d         = err_q;
    ifu_resp_d    = 1'b0;
    lsu_resp_d    = 1'b0;
    ifu_rdata_d   = '0;
    lsu_rdata_d   = '0;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    finish        = 1'b0;
    resp_data     = '0;

    case (state_q)
      ARB_IDLE: begin
        // Ready is withheld while reset is asserted so no grant is visible.
        if (rst_n && (grant != 2'b00)) begin
          owner_d = grant_owner(grant);
          last_d  = grant_owner(grant);
          cnt_d   = '0;
          state_d = ARB_ISSUE;
          if (grant[GNT_LSU]) begin
            lsu_req_ready = 1'b1;
            addr_d        = lsu_addr;
            wdata_d       = lsu_wdata;
            wmask_d       = lsu_wmask;
            wen_d         = lsu_wen;
            ren_d         = ~lsu_wen;
          end else begin
            ifu_req_ready = 1'b1;
            addr_d        = ifu_addr;
            wdata_d       = '0;
            wmask_d       = '0;
            wen_d         = 1'b0;
            ren_d         = 1'b1;
          end
        end
      end
      ARB_ISSUE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout_hit) begin
          err_d  = 1'b1;
          finish = 1'b1;
        end else if (mem_req_ready) begin
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout_hit) begin
          err_d  = 1'b1;
          finish = 1'b1;
        end else if (mem_resp_valid) begin
          finish    = 1'b1;
          resp_data = wen_q ? '0 : mem_rdata;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // A finished transaction (response or abort) pulses its owner next cycle.
    if (finish) begin
      state_d = ARB_IDLE;
      if (owner_q == ARB_OWN_LSU) begin
        lsu_resp_d  = 1'b1;
        lsu_rdata_d = resp_data;
      end else begin
        ifu_resp_d  = 1'b1;
        ifu_rdata_d = resp_data;
      end
    end
  end

  // State and output registers; reset clears everything including the buses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      owner_q     <= ARB_OWN_IFU;
      last_q      <= ARB_OWN_IFU;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      err_q       <= 1'b0;
      ifu_resp_q  <= 1'b0;
      lsu_resp_q  <= 1'b0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      err_q       <= err_d;
      ifu_resp_q  <= ifu_resp_d;
      lsu_resp_q  <= lsu_resp_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
    end
  end

  assign mem_req_valid  = (state_q == ARB_ISSUE);
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign mem_wen        = wen_q;
  assign mem_ren        = ren_q;
  assign mem_err        = err_q;
  assign ifu_resp_valid = ifu_resp_q;
  assign ifu_rdata      = ifu_rdata_q;
  assign lsu_resp_valid = lsu_resp_q;
  assign lsu_rdata      = lsu_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 uses fixed LSU priority with the default
// watchdog, instance 1 uses round-robin with a short watchdog. Both see the
// same inputs; sel chooses which instance is compared.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ifu_req_valid, lsu_req_valid, lsu_wen;
  logic        mem_req_ready, mem_resp_valid;
  logic [31:0] ifu_addr, lsu_addr;
  logic [63:0] lsu_wdata, mem_rdata;
  logic [7:0]  lsu_wmask;

  logic        ifu_req_ready_w [2];
  logic        ifu_resp_valid_w[2];
  logic [63:0] ifu_rdata_w     [2];
  logic        lsu_req_ready_w [2];
  logic        lsu_resp_valid_w[2];
  logic [63:0] lsu_rdata_w     [2];
  logic        mem_req_valid_w [2];
  logic [31:0] mem_addr_w      [2];
  logic [63:0] mem_wdata_w     [2];
  logic [7:0]  mem_wmask_w     [2];
  logic        mem_wen_w       [2];
  logic        mem_ren_w       [2];
  logic        mem_err_w       [2];

  int sel = 0;
  int n_cmp = 0;
  int n_fail = 0;

  mem_arbiter #(.RR_EN(0), .TIMEOUT(255)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready_w[0]), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid_w[0]), .ifu_rdata(ifu_rdata_w[0]),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready_w[0]), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid_w[0]), .lsu_rdata(lsu_rdata_w[0]),
    .mem_req_valid(mem_req_valid_w[0]), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr_w[0]), .mem_wdata(mem_wdata_w[0]), .mem_wmask(mem_wmask_w[0]),
    .mem_wen(mem_wen_w[0]), .mem_ren(mem_ren_w[0]),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_err(mem_err_w[0])
  );

  mem_arbiter #(.RR_EN(1), .TIMEOUT(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready_w[1]), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid_w[1]), .ifu_rdata(ifu_rdata_w[1]),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready_w[1]), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid_w[1]), .lsu_rdata(lsu_rdata_w[1]),
    .mem_req_valid(mem_req_valid_w[1]), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr_w[1]), .mem_wdata(mem_wdata_w[1]), .mem_wmask(mem_wmask_w[1]),
    .mem_wen(mem_wen_w[1]), .mem_ren(mem_ren_w[1]),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_err(mem_err_w[1])
  );

  // in: {rst_n, ifu_v, lsu_v, lsu_wen, mem_ready, mem_resp}
  // ex: {ifu_ready, lsu_ready, mem_req_valid, ifu_resp, lsu_resp}
  // wr: {mem_wen, mem_ren, check store data}
  typedef struct {
    logic [5:0]  in;
    logic [63:0] md;
    logic [4:0]  ex;
    logic [63:0] ed;
    logic [2:0]  wr;
    logic [31:0] ea;
  } vec_t;

  vec_t tbl[23];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] in, input logic [63:0] md);
    rst_n          = in[5];
    ifu_req_valid  = in[4];
    lsu_req_valid  = in[3];
    lsu_wen        = in[2];
    mem_req_ready  = in[1];
    mem_resp_valid = in[0];
    mem_rdata      = md;
  endtask

  initial begin
    int g_cnt;
    int g_own[8];
    int pulse_at;

    ifu_addr  = 32'h0000_1000;
    lsu_addr  = 32'h8000_0010;
    lsu_wdata = 64'h1122_3344_5566_7788;
    lsu_wmask = 8'hFF;
    drive(6'b000000, 64'h0);

    tbl[0]  = '{6'b000000, 64'h0,                5'b00000, 64'h0,                3'b000, 32'h0};
    tbl[1]  = '{6'b110000, 64'h0,                5'b10000, 64'h0,                3'b000, 32'h0};
    tbl[2]  = '{6'b100010, 64'h0,                5'b00100, 64'h0,                3'b010, 32'h0000_1000};
    tbl[3]  = '{6'b100001, 64'hDEAD_BEEF,        5'b00000, 64'h0,                3'b010, 32'h0000_1000};
    tbl[4]  = '{6'b100000, 64'h0,                5'b00010, 64'hDEAD_BEEF,        3'b010, 32'h0000_1000};
    tbl[5]  = '{6'b100000, 64'h0,                5'b00000, 64'h0,                3'b010, 32'h0000_1000};
    tbl[6]  = '{6'b111000, 64'h0,                5'b01000, 64'h0,                3'b010, 32'h0000_1000};
    tbl[7]  = '{6'b110010, 64'h0,                5'b00100, 64'h0,                3'b010, 32'h8000_0010};
    tbl[8]  = '{6'b110001, 64'hA5A5_A5A5_5A5A_5A5A, 5'b00000, 64'h0,             3'b010, 32'h8000_0010};
    tbl[9]  = '{6'b110000, 64'h0,                5'b10001, 64'hA5A5_A5A5_5A5A_5A5A, 3'b010, 32'h8000_0010};
    tbl[10] = '{6'b100010, 64'h0,                5'b00100, 64'h0,                3'b010, 32'h0000_1000};
    tbl[11] = '{6'b100001, 64'h0123_4567_89AB_CDEF, 5'b00000, 64'h0,             3'b010, 32'h0000_1000};
    tbl[12] = '{6'b100000, 64'h0,                5'b00010, 64'h0123_4567_89AB_CDEF, 3'b010, 32'h0000_1000};
    tbl[13] = '{6'b100001, 64'hFFFF_FFFF_FFFF_FFFF, 5'b00000, 64'h0,             3'b010, 32'h0000_1000};
    tbl[14] = '{6'b100000, 64'h0,                5'b00000, 64'h0,                3'b010, 32'h0000_1000};
    tbl[15] = '{6'b101100, 64'h0,                5'b01000, 64'h0,                3'b010, 32'h0000_1000};
    tbl[16] = '{6'b100000, 64'h0,                5'b00100, 64'h0,                3'b101, 32'h8000_0010};
    tbl[17] = '{6'b100001, 64'h1234,             5'b00100, 64'h0,                3'b101, 32'h8000_0010};
    tbl[18] = '{6'b100000, 64'h0,                5'b00100, 64'h0,                3'b101, 32'h8000_0010};
    tbl[19] = '{6'b100010, 64'h0,                5'b00100, 64'h0,                3'b101, 32'h8000_0010};
    tbl[20] = '{6'b100001, 64'hDEAD_BEEF,        5'b00000, 64'h0,                3'b101, 32'h8000_0010};
    tbl[21] = '{6'b100000, 64'h0,                5'b00001, 64'h0,                3'b101, 32'h8000_0010};
    tbl[22] = '{6'b100000, 64'h0,                5'b00000, 64'h0,                3'b101, 32'h8000_0010};

    tick();

    // Fixed-priority instance, cycle-by-cycle vectors.
    sel = 0;
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].in, tbl[i].md);
      #1;
      chk($sformatf("v%0d.ifu_ready", i), ifu_req_ready_w[sel],  tbl[i].ex[4]);
      chk($sformatf("v%0d.lsu_ready", i), lsu_req_ready_w[sel],  tbl[i].ex[3]);
      chk($sformatf("v%0d.mem_req",   i), mem_req_valid_w[sel],  tbl[i].ex[2]);
      chk($sformatf("v%0d.ifu_resp",  i), ifu_resp_valid_w[sel], tbl[i].ex[1]);
      chk($sformatf("v%0d.lsu_resp",  i), lsu_resp_valid_w[sel], tbl[i].ex[0]);
      chk($sformatf("v%0d.ifu_rdata", i), ifu_rdata_w[sel], tbl[i].ex[1] ? tbl[i].ed : 64'h0);
      chk($sformatf("v%0d.lsu_rdata", i), lsu_rdata_w[sel], tbl[i].ex[0] ? tbl[i].ed : 64'h0);
      chk($sformatf("v%0d.mem_wen",   i), mem_wen_w[sel],  tbl[i].wr[2]);
      chk($sformatf("v%0d.mem_ren",   i), mem_ren_w[sel],  tbl[i].wr[1]);
      chk($sformatf("v%0d.mem_addr",  i), mem_addr_w[sel], tbl[i].ea);
      chk($sformatf("v%0d.mem_err",   i), mem_err_w[sel],  1'b0);
      if (tbl[i].wr[0]) begin
        chk($sformatf("v%0d.mem_wdata", i), mem_wdata_w[sel], 64'h1122_3344_5566_7788);
        chk($sformatf("v%0d.mem_wmask", i), mem_wmask_w[sel], 8'hFF);
      end
      tick();
    end

    // Round-robin instance: both held valid, memory always ready/responding.
    sel = 1;
    drive(6'b000000, 64'h0);
    tick();
    drive(6'b111011, 64'h77);
    g_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      chk($sformatf("rr.c%0d.ready_excl", c),
          64'(ifu_req_ready_w[sel] & lsu_req_ready_w[sel]), 64'h0);
      chk($sformatf("rr.c%0d.resp_excl", c),
          64'(ifu_resp_valid_w[sel] & lsu_resp_valid_w[sel]), 64'h0);
      if (g_cnt < 8) begin
        if (lsu_req_ready_w[sel]) begin g_own[g_cnt] = 1; g_cnt++; end
        else if (ifu_req_ready_w[sel]) begin g_own[g_cnt] = 0; g_cnt++; end
      end
      tick();
    end
    drive(6'b100000, 64'h0);
    chk("rr.grant_count", 64'(g_cnt), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < g_cnt) chk($sformatf("rr.grant%0d_owner", k), 64'(g_own[k]), (k % 2 == 0) ? 64'd1 : 64'd0);
    end
    tick();
    tick();

    // Watchdog: IFU read accepted, memory takes the request but never answers.
    drive(6'b110010, 64'h0);
    #1;
    chk("wd.accept", ifu_req_ready_w[sel], 1'b1);
    tick();
    drive(6'b100010, 64'h0);
    pulse_at = -1;
    for (int k = 1; k <= 20; k++) begin
      #1;
      if (ifu_resp_valid_w[sel] || lsu_resp_valid_w[sel]) begin
        pulse_at = k;
        break;
      end
      tick();
    end
    chk("wd.pulse_cycle", 64'(pulse_at), 64'd6);
    chk("wd.ifu_resp",  ifu_resp_valid_w[sel], 1'b1);
    chk("wd.lsu_resp",  lsu_resp_valid_w[sel], 1'b0);
    chk("wd.ifu_rdata", ifu_rdata_w[sel], 64'h0);
    chk("wd.mem_err",   mem_err_w[sel], 1'b1);
    chk("wd.mem_req",   mem_req_valid_w[sel], 1'b0);
    tick();
    drive(6'b100001, 64'hFFFF_0000_FFFF_0000);
    #1;
    chk("wd.stray.ifu_resp0", ifu_resp_valid_w[sel], 1'b0);
    tick();
    drive(6'b100000, 64'h0);
    #1;
    chk("wd.stray.ifu_resp1", ifu_resp_valid_w[sel], 1'b0);
    chk("wd.stray.lsu_resp1", lsu_resp_valid_w[sel], 1'b0);
    chk("wd.err_sticky",      mem_err_w[sel], 1'b1);
    tick();

    // Reset while waiting for a response.
    drive(6'b110010, 64'h0);
    tick();
    drive(6'b100010, 64'h0);
    tick();
    drive(6'b000000, 64'h0);
    #1;
    chk("rst.pre_mem_req", mem_req_valid_w[sel], 1'b0);
    tick();
    drive(6'b100001, 64'hABCD_ABCD_ABCD_ABCD);
    #1;
    chk("rst.mem_req",   mem_req_valid_w[sel], 1'b0);
    chk("rst.mem_addr",  mem_addr_w[sel],  32'h0);
    chk("rst.mem_wdata", mem_wdata_w[sel], 64'h0);
    chk("rst.mem_wmask", mem_wmask_w[sel], 8'h0);
    chk("rst.mem_wen",   mem_wen_w[sel],   1'b0);
    chk("rst.mem_ren",   mem_ren_w[sel],   1'b0);
    chk("rst.mem_err",   mem_err_w[sel],   1'b0);
    chk("rst.ifu_resp",  ifu_resp_valid_w[sel], 1'b0);
    chk("rst.lsu_resp",  lsu_resp_valid_w[sel], 1'b0);
    chk("rst.ifu_rdata", ifu_rdata_w[sel], 64'h0);
    chk("rst.lsu_rdata", lsu_rdata_w[sel], 64'h0);
    tick();
    drive(6'b110000, 64'h0);
    #1;
    chk("rst.late_ifu_resp", ifu_resp_valid_w[sel], 1'b0);
    chk("rst.late_lsu_resp", lsu_resp_valid_w[sel], 1'b0);
    chk("rst.idle_grant",    ifu_req_ready_w[sel],  1'b1);
    tick();
    drive(6'b100000, 64'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
